// File: rtl/serial_mag_compare_pkg.sv
// -----------------------------------------------------------------------------
// cmp_pkg
// Shared definitions for the serial magnitude comparator:
//   - state encoding (2-bit) for the scan FSM
//   - default operand width and digit size
//   - helper function returning the digit-index width, clog2(WIDTH/DIGIT)
// -----------------------------------------------------------------------------
package cmp_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DIGIT = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Width of the digit index; a single-digit configuration still gets one bit
    // so the index register never collapses to zero width.
    function automatic int idx_width(input int width, input int digit);
        int n;
        n = width / digit;
        if (n <= 1) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

    localparam int DEFAULT_IDX_W = idx_width(DEFAULT_WIDTH, DEFAULT_DIGIT);

endpackage

// File: rtl/serial_mag_compare_digit_compare.sv
// -----------------------------------------------------------------------------
// digit_compare
// Combinational unsigned compare of one DIGIT-bit digit pair.
// Ports:
//   a_dig  in  DIGIT  digit of the left operand
//   b_dig  in  DIGIT  digit of the right operand
//   dgt    out 1      a_dig > b_dig
//   dlt    out 1      a_dig < b_dig
// Both outputs low means the digits are equal.
// -----------------------------------------------------------------------------
module digit_compare
    import cmp_pkg::*;
#(
    parameter int DIGIT = DEFAULT_DIGIT
) (
    input  logic [DIGIT-1:0] a_dig,
    input  logic [DIGIT-1:0] b_dig,
    output logic             dgt,
    output logic             dlt
);

    assign dgt = (a_dig > b_dig);
    assign dlt = (a_dig < b_dig);

endmodule

// File: rtl/serial_mag_compare.sv
// -----------------------------------------------------------------------------
// serial_mag_compare
// Multi-cycle magnitude comparator. Operands are captured on accept and scanned
// MSB-first one DIGIT-bit digit per cycle; the scan stops at the first
// differing digit. Signed compares are turned into unsigned ones by inverting
// the sign bit of both captured operands.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   flush      in   synchronous abort back to IDLE, drops any pending result
//   cmd_valid  in   command present
//   cmd_ready  out  command can be accepted (IDLE only)
//   a, b       in   WIDTH-bit operands
//   is_signed  in   1 = two's-complement compare
//   res_valid  out  result available
//   res_ready  in   consumer takes the result
//   lt/eq/gt   out  one-hot result while res_valid is high
//   busy       out  scanning or holding a result
// -----------------------------------------------------------------------------
module serial_mag_compare
    import cmp_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DIGIT = DEFAULT_DIGIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             lt,
    output logic             eq,
    output logic             gt,
    output logic             busy
);

    localparam int N    = WIDTH / DIGIT;
    localparam int IW   = idx_width(WIDTH, DIGIT);
    localparam logic [IW-1:0]    IDX_TOP   = IW'(N - 1);
    localparam logic [IW-1:0]    IDX_ZERO  = {IW{1'b0}};
    localparam logic [IW-1:0]    IDX_ONE   = IW'(1);
    localparam logic [WIDTH-1:0] SIGN_MASK = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             lt_q, lt_d;
    logic             eq_q, eq_d;
    logic             gt_q, gt_d;
    logic             res_valid_q, res_valid_d;
    logic             busy_q, busy_d;

    logic [DIGIT-1:0] a_dig;
    logic [DIGIT-1:0] b_dig;
    logic             dgt;
    logic             dlt;

    // Select the digit under examination from the captured operands.
    always_comb begin
        a_dig = a_q[int'(idx_q)*DIGIT +: DIGIT];
        b_dig = b_q[int'(idx_q)*DIGIT +: DIGIT];
    end

    digit_compare #(
        .DIGIT (DIGIT)
    ) u_digit_compare (
        .a_dig (a_dig),
        .b_dig (b_dig),
        .dgt   (dgt),
        .dlt   (dlt)
    );

    // Next-state and next-output computation for the scan FSM.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        idx_d       = idx_q;
        lt_d        = lt_q;
        eq_d        = eq_q;
        gt_d        = gt_q;
        res_valid_d = res_valid_q;
        busy_d      = busy_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    // Biasing the sign bit maps two's-complement order onto
                    // unsigned order, so the scan itself is always unsigned.
                    if (is_signed) begin
                        a_d = a ^ SIGN_MASK;
                        b_d = b ^ SIGN_MASK;
                    end else begin
                        a_d = a;
                        b_d = b;
                    end
                    lt_d    = 1'b0;
                    eq_d    = 1'b0;
                    gt_d    = 1'b0;
                    idx_d   = IDX_TOP;
                    busy_d  = 1'b1;
                    state_d = S_SCAN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SCAN: begin
                if (dgt) begin
                    gt_d        = 1'b1;
                    res_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else if (dlt) begin
                    lt_d        = 1'b1;
                    res_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else if (idx_q == IDX_ZERO) begin
                    // Last digit equal: exit here so idx never wraps.
                    eq_d        = 1'b1;
                    res_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    idx_d   = idx_q - IDX_ONE;
                    state_d = S_SCAN;
                end
            end
            S_DONE: begin
                if (res_ready) begin
                    // lt/eq/gt keep their values until the next accept.
                    res_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                res_valid_d = 1'b0;
                busy_d      = 1'b0;
                idx_d       = IDX_TOP;
                state_d     = S_IDLE;
            end
        endcase

        // Abort overrides any accept or handshake decided above.
        if (flush) begin
            state_d     = S_IDLE;
            res_valid_d = 1'b0;
            busy_d      = 1'b0;
            idx_d       = IDX_TOP;
        end else begin
            state_d = state_d;
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_q         <= {WIDTH{1'b0}};
            b_q         <= {WIDTH{1'b0}};
            idx_q       <= IDX_TOP;
            lt_q        <= 1'b0;
            eq_q        <= 1'b0;
            gt_q        <= 1'b0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            idx_q       <= idx_d;
            lt_q        <= lt_d;
            eq_q        <= eq_d;
            gt_q        <= gt_d;
            res_valid_q <= res_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign res_valid = res_valid_q;
    assign lt        = lt_q;
    assign eq        = eq_q;
    assign gt        = gt_q;
    assign busy      = busy_q;

endmodule

// File: doc/serial_mag_compare.md
Name: serial_mag_compare

Overview:
- Multi-cycle magnitude comparator for two WIDTH-bit operands.
- Scans MSB-first, one DIGIT-bit digit per cycle, and terminates at the first differing digit.
- Serves as the area-lean counterpart to the LSB-first combinational ripple comparator; used by branch/SLT paths that can tolerate latency.
- Supports signed and unsigned modes, with valid/ready handshakes on the command and result sides.

Parameters:
- WIDTH, 32, operand width in bits.
- DIGIT, 4, bits compared per cycle; must divide WIDTH. N = WIDTH/DIGIT digits.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous abort; highest priority after rst.
- cmd_valid  input  1  operands/mode presented.
- cmd_ready  output  1  block can accept a command (high only in IDLE).
- a  input  WIDTH  left operand.
- b  input  WIDTH  right operand.
- is_signed  input  1  1 = two's-complement compare, 0 = unsigned.
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts result.
- lt  output  1  a < b.
- eq  output  1  a == b.
- gt  output  1  a > b.
- busy  output  1  high in SCAN or DONE.

Behaviour:
- Reset: state=IDLE; cmd_ready=1 (combinational from IDLE); res_valid=0; lt=eq=gt=0; busy=0; digit index=N-1. Outputs clear immediately on rst assertion, in any state.
- States:
  - IDLE: accept on cmd_valid&cmd_ready. Capture a, b; if is_signed, invert bit WIDTH-1 of both captured copies (bias to unsigned). Clear lt/eq/gt; idx=N-1; go to SCAN.
  - SCAN: each cycle compare digit idx of the captured operands.
    - a_digit > b_digit: gt=1, go to DONE.
    - a_digit < b_digit: lt=1, go to DONE.
    - digits equal and idx==0: eq=1, go to DONE.
    - otherwise: idx <= idx-1, stay in SCAN.
  - DONE: res_valid=1; lt/eq/gt held stable. On res_valid&res_ready, go to IDLE, res_valid=0; lt/eq/gt hold their last values until the next accept.
- Exactly one of lt/eq/gt is 1 whenever res_valid=1.
- Latency: accept edge to res_valid edge is k = 1 + (N-1 - j) cycles, where j is the highest differing digit. Equal operands take N cycles. Range is 1..N.
- No overlap: cmd_ready=0 in SCAN and DONE. cmd_valid is ignored there and is not queued. A new command is accepted at the earliest one cycle after the result handshake.
- flush=1 at an edge: the next state is IDLE and res_valid=0, from any state. A result pending in DONE is discarded. flush wins over a simultaneous cmd accept or result handshake.
- idx never underflows; the idx==0 equal case exits to DONE.
- Captured operands are unaffected by changes on a/b after accept.

Decomposition:
- Shared package cmp_pkg holds:
  - state encoding constants S_IDLE/S_SCAN/S_DONE (2-bit);
  - default WIDTH/DIGIT;
  - a localparam function computing the idx width, clog2(N).
- One natural sub-module: digit_compare. It is combinational, DIGIT-bit unsigned inputs, outputs dgt/dlt, and is instantiated once on the digit muxed by idx.

Test Plan:
- a=0x80000000, b=0x00000001, is_signed=0 -> gt=1 one cycle after accept. Same operands with is_signed=1 -> lt=1, one cycle.
- a=b=0x12345678 -> eq=1, res_valid exactly 8 cycles after accept, lt=gt=0.
- a=0x00000005, b=0x00000007, unsigned -> lt=1 after 8 cycles. a=0x0F000000, b=0x0E000000 -> gt=1 after 2 cycles.
- Result backpressure: hold res_ready=0 for 5 cycles after res_valid while driving cmd_valid=1 -> lt/eq/gt/res_valid stable, cmd_ready=0. Raise res_ready -> IDLE next edge, and the pending cmd is accepted the following cycle.
- Flush during SCAN on the 3rd cycle of an equal-operand compare -> IDLE next edge, res_valid never asserted, busy=0. A subsequent cmd a=0xFFFFFFFF, b=0 signed -> lt=1 in 1 cycle.
- Assert rst asynchronously (between edges) while in DONE -> res_valid, lt/eq/gt, busy drop to 0 before the next edge. After release, cmd_ready=1.
